// File: rtl/gpif_ii_master.sv
// FPGA-side master for the FX3 GPIF II synchronous slave FIFO: pushes the TX stream into the
// write socket and drains the read socket into the RX stream, with a fixed-latency read pipeline.
module gpif_ii_master #(
   parameter logic [1:0] TX_ADDR    = 2'b00,
   parameter logic [1:0] RX_ADDR    = 2'b11,
   parameter int         RD_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] tx_data,
   input  logic        tx_valid,
   input  logic        tx_last,
   output logic        tx_ready,
   output logic [31:0] rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        PCLK,
   output logic [1:0]  address,
   output logic [31:0] data_ms,
   input  logic [31:0] data_sm,
   input  logic        data_t,
   output logic        SLCS_n,
   output logic        SLWR_n,
   output logic        SLRD_n,
   output logic        SLOE_n,
   output logic        PKTEND_n,
   input  logic        FLAGA,
   input  logic        FLAGB,
   input  logic        FLAGC,
   input  logic        FLAGD
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, RD_DRAIN, TURN} state_t;

   state_t                  state_q, state_d;
   logic                    flaga_q, flagb_q, flagc_q, flagd_q;
   logic [1:0]              address_q, address_d;
   logic [31:0]             data_ms_q, data_ms_d;
   logic                    slwr_n_q, slwr_n_d;
   logic                    pktend_n_q, pktend_n_d;
   logic                    rd_arm_q, rd_arm_d;
   logic [RD_LATENCY-1:0]   rd_pipe_q, rd_pipe_d;

   // Flags settle late in the cycle, so only registered copies feed decisions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flaga_q    <= 1'b0;
         flagb_q    <= 1'b0;
         flagc_q    <= 1'b0;
         flagd_q    <= 1'b0;
         state_q    <= IDLE;
         address_q  <= TX_ADDR;
         data_ms_q  <= '0;
         slwr_n_q   <= 1'b1;
         pktend_n_q <= 1'b1;
         rd_arm_q   <= 1'b0;
         rd_pipe_q  <= '0;
      end else begin
         flaga_q    <= FLAGA;
         flagb_q    <= FLAGB;
         flagc_q    <= FLAGC;
         flagd_q    <= FLAGD;
         state_q    <= state_d;
         address_q  <= address_d;
         data_ms_q  <= data_ms_d;
         slwr_n_q   <= slwr_n_d;
         pktend_n_q <= pktend_n_d;
         rd_arm_q   <= rd_arm_d;
         rd_pipe_q  <= rd_pipe_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      address_d  = address_q;
      data_ms_d  = data_ms_q;
      slwr_n_d   = 1'b1;
      pktend_n_d = 1'b1;
      rd_arm_d   = 1'b0;
      tx_ready   = 1'b0;
      SLCS_n     = (state_q == IDLE);
      SLOE_n     = 1'b1;
      SLRD_n     = 1'b1;

      case (state_q)
         IDLE: begin
            if (flagc_q && rx_ready) begin
               address_d = RX_ADDR;
               state_d   = READ;
            end else if (tx_valid && flaga_q) begin
               address_d = TX_ADDR;
               state_d   = WRITE;
            end
         end
         WRITE: begin
            tx_ready = flagb_q;
            if (tx_valid && flagb_q) begin
               slwr_n_d   = 1'b0;
               data_ms_d  = tx_data;
               pktend_n_d = ~tx_last;
               if (tx_last) state_d = TURN;
            end else begin
               state_d = TURN;
            end
         end
         READ: begin
            // First READ cycle only settles address/OE; reads start the cycle after.
            SLOE_n   = 1'b0;
            rd_arm_d = 1'b1;
            if (flagd_q && rx_ready) SLRD_n = ~rd_arm_q;
            else                     state_d = RD_DRAIN;
         end
         RD_DRAIN: SLOE_n = 1'b0;
         TURN:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      rd_pipe_d[0] = ~SLRD_n;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe_d[i] = rd_pipe_q[i-1];

      // Hold OE through the cycle that returns the last in-flight word.
      if (state_q == RD_DRAIN && rd_pipe_d == '0) state_d = TURN;
   end

   assign rx_valid = rd_pipe_q[RD_LATENCY-1] & data_t;
   assign rx_data  = rx_valid ? data_sm : '0;
   assign PCLK     = clk;
   assign address  = address_q;
   assign data_ms  = data_ms_q;
   assign SLWR_n   = slwr_n_q;
   assign PKTEND_n = pktend_n_q;

endmodule

// File: tb/tb_gpif_ii_master.sv
// Directed bench for gpif_ii_master with a small FX3 read-socket model and bus monitors.
module tb_gpif_ii_master;
   localparam int RDL = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] tx_data;
   logic        tx_valid, tx_last, tx_ready;
   logic [31:0] rx_data;
   logic        rx_valid, rx_ready;
   logic        PCLK;
   logic [1:0]  address;
   logic [31:0] data_ms;
   logic [31:0] data_sm = 32'h0;
   logic        data_t;
   logic        SLCS_n, SLWR_n, SLRD_n, SLOE_n, PKTEND_n;
   logic        FLAGA, FLAGB;
   logic        FLAGC = 1'b0;
   logic        FLAGD = 1'b0;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int inv_bad = 0;

   // FX3 read-socket model state and monitor logs
   int          rd_avail = 0;
   int          rdn = 0;
   logic [31:0] rd_tab [0:7];
   int          rd_cyc [0:63];
   int          due_q [$];
   logic [31:0] dat_q [$];
   int          rxn = 0;
   logic [31:0] rx_dat [0:63];
   int          rx_cyc [0:63];
   logic        rx_oe [0:63];
   int          wrn = 0;
   logic [31:0] wr_dat [0:63];
   logic        wr_pkt [0:63];
   logic [1:0]  wr_adr [0:63];
   int          wr_cyc [0:63];

   gpif_ii_master #(.TX_ADDR(2'b00), .RX_ADDR(2'b11), .RD_LATENCY(RDL)) dut (
      .clk(clk), .rst_n(rst_n),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .PCLK(PCLK), .address(address), .data_ms(data_ms), .data_sm(data_sm), .data_t(data_t),
      .SLCS_n(SLCS_n), .SLWR_n(SLWR_n), .SLRD_n(SLRD_n), .SLOE_n(SLOE_n), .PKTEND_n(PKTEND_n),
      .FLAGA(FLAGA), .FLAGB(FLAGB), .FLAGC(FLAGC), .FLAGD(FLAGD)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitors sample first, then the FX3 model updates its outputs for the next cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if ((!SLWR_n && !SLRD_n) || (!SLOE_n && !SLWR_n) || (!PKTEND_n && SLWR_n)) begin
            inv_bad++;
            $display("FAIL bus_invariant: cycle %0d SLWR_n=%b SLRD_n=%b SLOE_n=%b PKTEND_n=%b",
                     cyc, SLWR_n, SLRD_n, SLOE_n, PKTEND_n);
         end
      end
      if (!SLWR_n && wrn < 64) begin
         wr_dat[wrn] = data_ms; wr_pkt[wrn] = !PKTEND_n; wr_adr[wrn] = address; wr_cyc[wrn] = cyc;
         wrn++;
      end
      if (rx_valid && rxn < 64) begin
         rx_dat[rxn] = rx_data; rx_cyc[rxn] = cyc; rx_oe[rxn] = !SLOE_n;
         rxn++;
      end
      if (!SLRD_n && rdn < 64) begin
         rd_cyc[rdn] = cyc;
         due_q.push_back(cyc + RDL);
         dat_q.push_back(rd_tab[rdn % 8]);
         rdn++;
      end
      if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
         data_sm = dat_q[0];
         void'(due_q.pop_front());
         void'(dat_q.pop_front());
      end
      FLAGC = (rdn < rd_avail);
      FLAGD = (rdn < rd_avail);
   end

   // Feeds n words from base; optionally drops FLAGB after drop_at accepts and restores it later.
   task automatic drive_burst(input logic [31:0] base, input int n, input int drop_at,
                              output logic rdy_after_drop, output bit done);
      int  i = 0;
      int  dc = 0;
      int  budget = 0;
      bit  dropped = 0;
      logic acc;
      rdy_after_drop = 1'bx;
      while (i < n && budget < 200) begin
         tx_valid = 1'b1; tx_data = base + i; tx_last = (i == n - 1);
         @(negedge clk);
         acc = tx_ready;
         if (dropped) begin
            dc++;
            if (dc == 2) rdy_after_drop = tx_ready;
         end
         @(posedge clk); #1;
         budget++;
         if (acc) i++;
         if (drop_at >= 0 && i == drop_at && !dropped) begin FLAGB = 1'b0; dropped = 1; end
         if (dc == 6) FLAGB = 1'b1;
      end
      tx_valid = 1'b0; tx_last = 1'b0;
      done = (i == n);
   endtask

   task automatic test_reset;
      bit seen = 0;
      repeat (2) @(negedge clk);
      checks++; if (SLCS_n !== 1'b1)   $display("FAIL rst_slcs: got %b want 1", SLCS_n);   else passed++;
      checks++; if (SLWR_n !== 1'b1)   $display("FAIL rst_slwr: got %b want 1", SLWR_n);   else passed++;
      checks++; if (SLRD_n !== 1'b1)   $display("FAIL rst_slrd: got %b want 1", SLRD_n);   else passed++;
      checks++; if (SLOE_n !== 1'b1)   $display("FAIL rst_sloe: got %b want 1", SLOE_n);   else passed++;
      checks++; if (PKTEND_n !== 1'b1) $display("FAIL rst_pktend: got %b want 1", PKTEND_n); else passed++;
      checks++; if (address !== 2'b00) $display("FAIL rst_addr: got %b want 00", address); else passed++;
      checks++; if (data_ms !== 32'h0) $display("FAIL rst_data_ms: got %h want 0", data_ms); else passed++;
      checks++; if (tx_ready !== 1'b0) $display("FAIL rst_tx_ready: got %b want 0", tx_ready); else passed++;
      checks++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", rx_valid); else passed++;
      checks++; if (rx_data !== 32'h0) $display("FAIL rst_rx_data: got %h want 0", rx_data); else passed++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b1; tx_data = 32'h55; tx_last = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (SLWR_n === 1'b0) seen = 1;
      end
      checks++; if (!seen) $display("FAIL rst_write_start: got no SLWR_n low want one"); else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (SLWR_n !== 1'b1) $display("FAIL midrst_slwr: got %b want 1", SLWR_n); else passed++;
      checks++; if (SLCS_n !== 1'b1) $display("FAIL midrst_slcs: got %b want 1", SLCS_n); else passed++;
      checks++; if (rx_valid !== 1'b0) $display("FAIL midrst_rx_valid: got %b want 0", rx_valid); else passed++;
      tx_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (SLCS_n !== 1'b1) $display("FAIL post_rst_idle: SLCS_n got %b want 1", SLCS_n); else passed++;
      checks++; if (tx_ready !== 1'b0) $display("FAIL post_rst_tx_ready: got %b want 0", tx_ready); else passed++;
   endtask

   task automatic test_tx_burst;
      int   w0 = wrn;
      logic rdy;
      bit   done;
      drive_burst(32'hA0, 4, -1, rdy, done);
      checks++; if (!done) $display("FAIL tx_burst_timeout: accepted fewer than 4 words"); else passed++;
      @(negedge clk);
      checks++; if (PKTEND_n !== 1'b0 || data_ms !== 32'hA3)
         $display("FAIL tx_pktend_last: PKTEND_n=%b data_ms=%h want 0/000000a3", PKTEND_n, data_ms); else passed++;
      checks++; if (SLCS_n !== 1'b0) $display("FAIL tx_turn_cs: got %b want 0", SLCS_n); else passed++;
      @(negedge clk);
      checks++; if (SLCS_n !== 1'b1 || SLWR_n !== 1'b1)
         $display("FAIL tx_back_idle: SLCS_n=%b SLWR_n=%b want 1/1", SLCS_n, SLWR_n); else passed++;
      checks++; if (wrn - w0 !== 4) $display("FAIL tx_count: got %0d want 4", wrn - w0); else passed++;
      for (int k = 0; k < 4; k++) begin
         checks++; if (wr_dat[w0+k] !== 32'hA0 + k)
            $display("FAIL tx_data%0d: got %h want %h", k, wr_dat[w0+k], 32'hA0 + k); else passed++;
         checks++; if (wr_pkt[w0+k] !== (k == 3))
            $display("FAIL tx_pkt%0d: got %b want %b", k, wr_pkt[w0+k], (k == 3)); else passed++;
         checks++; if (wr_adr[w0+k] !== 2'b00)
            $display("FAIL tx_addr%0d: got %b want 00", k, wr_adr[w0+k]); else passed++;
      end
   endtask

   task automatic test_flagb_drop;
      int   w0 = wrn;
      logic rdy;
      bit   done;
      drive_burst(32'hB0, 6, 2, rdy, done);
      repeat (4) @(posedge clk);
      checks++; if (!done) $display("FAIL flagb_timeout: burst did not complete"); else passed++;
      checks++; if (rdy !== 1'b0) $display("FAIL flagb_tx_ready: got %b want 0", rdy); else passed++;
      checks++; if (wrn - w0 !== 6) $display("FAIL flagb_count: got %0d want 6", wrn - w0); else passed++;
      for (int k = 0; k < 6; k++) begin
         checks++; if (wr_dat[w0+k] !== 32'hB0 + k)
            $display("FAIL flagb_data%0d: got %h want %h", k, wr_dat[w0+k], 32'hB0 + k); else passed++;
      end
   endtask

   task automatic test_read;
      int r0 = rxn;
      int d0 = rdn;
      rd_tab[d0 % 8] = 32'h11; rd_tab[(d0+1) % 8] = 32'h22; rd_tab[(d0+2) % 8] = 32'h33;
      rx_ready = 1'b1;
      rd_avail = d0 + 3;
      repeat (25) @(posedge clk);
      #1;
      checks++; if (rdn - d0 !== 3) $display("FAIL rd_issue_count: got %0d want 3", rdn - d0); else passed++;
      checks++; if (rxn - r0 !== 3) $display("FAIL rd_rx_count: got %0d want 3", rxn - r0); else passed++;
      for (int k = 0; k < 3; k++) begin
         checks++; if (rx_dat[r0+k] !== 32'h11 * (k + 1))
            $display("FAIL rd_data%0d: got %h want %h", k, rx_dat[r0+k], 32'h11 * (k + 1)); else passed++;
         checks++; if (rx_cyc[r0+k] - rd_cyc[d0+k] !== RDL)
            $display("FAIL rd_latency%0d: got %0d want %0d", k, rx_cyc[r0+k] - rd_cyc[d0+k], RDL); else passed++;
         checks++; if (rx_oe[r0+k] !== 1'b1)
            $display("FAIL rd_oe_held%0d: got %b want 1", k, rx_oe[r0+k]); else passed++;
      end
      @(negedge clk);
      checks++; if (SLOE_n !== 1'b1 || SLCS_n !== 1'b1)
         $display("FAIL rd_end_idle: SLOE_n=%b SLCS_n=%b want 1/1", SLOE_n, SLCS_n); else passed++;
   endtask

   task automatic test_priority;
      int   r0 = rxn;
      int   w0 = wrn;
      int   d0 = rdn;
      logic acc = 1'b0;
      rx_ready = 1'b0;
      rd_tab[d0 % 8] = 32'h44;
      rd_avail = d0 + 1;
      repeat (2) @(posedge clk);
      #1;
      rx_ready = 1'b1;
      tx_valid = 1'b1; tx_data = 32'hC0; tx_last = 1'b1;
      for (int k = 0; k < 40 && !acc; k++) begin
         @(negedge clk); acc = tx_ready;
         @(posedge clk); #1;
      end
      tx_valid = 1'b0; tx_last = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (rxn - r0 !== 1 || rx_dat[r0] !== 32'h44)
         $display("FAIL prio_rx: count %0d data %h want 1/00000044", rxn - r0, rx_dat[r0]); else passed++;
      checks++; if (wrn - w0 !== 1 || wr_dat[w0] !== 32'hC0)
         $display("FAIL prio_tx: count %0d data %h want 1/000000c0", wrn - w0, wr_dat[w0]); else passed++;
      checks++; if (!(wr_cyc[w0] > rx_cyc[r0]))
         $display("FAIL prio_order: write cycle %0d rx cycle %0d want write later", wr_cyc[w0], rx_cyc[r0]); else passed++;
      checks++; if (!(wr_cyc[w0] > rd_cyc[d0] + 2))
         $display("FAIL prio_turn: write cycle %0d read cycle %0d want gap > 2", wr_cyc[w0], rd_cyc[d0]); else passed++;
   endtask

   task automatic test_invariants;
      checks++; if (inv_bad !== 0) $display("FAIL invariants: got %0d violations want 0", inv_bad); else passed++;
   endtask

   initial begin
      rst_n = 1'b0;
      tx_data = 32'h0; tx_valid = 1'b0; tx_last = 1'b0;
      rx_ready = 1'b0; data_t = 1'b1;
      FLAGA = 1'b1; FLAGB = 1'b1;
      for (int k = 0; k < 8; k++) rd_tab[k] = 32'h0;
      test_reset();
      test_tx_burst();
      test_flagb_drop();
      test_read();
      test_priority();
      test_invariants();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
